// File: rtl/rv32i_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I execute-stage definitions: ALU operation codes,
//               forwarding-select encodings, branch funct3 codes and the
//               EX/MEM pipeline register bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int unsigned RV_XLEN = 32;

    // ALU operation codes (idex_alu_op). Codes 11..15 are unused and yield 0.
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Forwarding-unit select encodings (11 behaves like FWD_REG).
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Conditional-branch funct3 codes.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // EX/MEM pipeline register contents.
    typedef struct packed {
        logic                   valid;
        logic [RV_XLEN-1:0]     alu_result;
        logic [RV_XLEN-1:0]     store_data;
        logic [4:0]             rd;
        logic [2:0]             funct3;
        logic                   regwrite;
        logic                   memread;
        logic                   memwrite;
        logic                   memtoreg;
    } exmem_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu
// Description : Combinational RV32I integer ALU.
//   a      in  XLEN  operand A
//   b      in  XLEN  operand B (shift amount taken from b[4:0])
//   op     in  4     operation code from rv32i_pkg
//   result out XLEN  operation result (0 for unused codes)
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);

    logic [4:0] w_shamt;
    logic       w_lt_signed;
    logic       w_lt_unsigned;

    assign w_shamt       = b[4:0];
    assign w_lt_signed   = ($signed(a) < $signed(b));
    assign w_lt_unsigned = (a < b);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << w_shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, w_lt_signed};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> w_shamt;
            ALU_SRA:   result = $signed(a) >>> w_shamt;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ex_stage
// Description : RV32I execute stage with EX/MEM pipeline register. Selects
//               forwarded ALU operands, computes the ALU result, resolves
//               branches/jumps (same-cycle redirect) and registers results
//               into EX/MEM.
//   clk, rst            clock / asynchronous active-high reset
//   idex_*              ID/EX instruction fields and controls
//   forward_a/b         operand forwarding selects (rs1 / rs2)
//   memwb_wdata         MEM/WB writeback value (forwarding source)
//   mem_stall           hold EX/MEM and suppress redirect
//   redirect_valid/pc   combinational taken-branch / jump redirect
//   exmem_*             registered EX/MEM outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            idex_valid,
    input  logic [XLEN-1:0] idex_pc,
    input  logic [XLEN-1:0] idex_rs1_data,
    input  logic [XLEN-1:0] idex_rs2_data,
    input  logic [XLEN-1:0] idex_imm,
    input  logic [4:0]      idex_rd,
    input  logic [3:0]      idex_alu_op,
    input  logic            idex_alusrc_a,
    input  logic            idex_alusrc_b,
    input  logic            idex_branch,
    input  logic            idex_jump,
    input  logic            idex_jalr,
    input  logic [2:0]      idex_funct3,
    input  logic            idex_memread,
    input  logic            idex_memwrite,
    input  logic            idex_regwrite,
    input  logic            idex_memtoreg,

    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] memwb_wdata,
    input  logic            mem_stall,

    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,

    output logic            exmem_valid,
    output logic [XLEN-1:0] exmem_alu_result,
    output logic [XLEN-1:0] exmem_store_data,
    output logic [4:0]      exmem_rd,
    output logic [2:0]      exmem_funct3,
    output logic            exmem_regwrite,
    output logic            exmem_memread,
    output logic            exmem_memwrite,
    output logic            exmem_memtoreg
);

    exmem_t          r_exmem;
    exmem_t          w_exmem_next;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_link;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_pc_rel_target;
    logic            w_cond_true;
    logic            w_is_jump;

    // ------------------------------------------------------------------
    // Operand forwarding. The EX/MEM source is the value currently held in
    // the register (before the coming edge), so back-to-back dependents see
    // the previous instruction's result.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_rs1 = idex_rs1_data;
        case (forward_a)
            FWD_EXMEM: w_fwd_rs1 = r_exmem.alu_result;
            FWD_MEMWB: w_fwd_rs1 = memwb_wdata;
            default:   w_fwd_rs1 = idex_rs1_data;
        endcase
    end

    always_comb begin
        w_fwd_rs2 = idex_rs2_data;
        case (forward_b)
            FWD_EXMEM: w_fwd_rs2 = r_exmem.alu_result;
            FWD_MEMWB: w_fwd_rs2 = memwb_wdata;
            default:   w_fwd_rs2 = idex_rs2_data;
        endcase
    end

    assign w_op_a = idex_alusrc_a ? idex_pc  : w_fwd_rs1;
    assign w_op_b = idex_alusrc_b ? idex_imm : w_fwd_rs2;

    alu #(
        .XLEN   (XLEN)
    ) u_alu (
        .a      (w_op_a),
        .b      (w_op_b),
        .op     (idex_alu_op),
        .result (w_alu_result)
    );

    // ------------------------------------------------------------------
    // Branch condition on forwarded register values. funct3 010/011 are
    // not branch encodings and never take.
    // ------------------------------------------------------------------
    always_comb begin
        w_cond_true = 1'b0;
        case (idex_funct3)
            F3_BEQ:  w_cond_true = (w_fwd_rs1 == w_fwd_rs2);
            F3_BNE:  w_cond_true = (w_fwd_rs1 != w_fwd_rs2);
            F3_BLT:  w_cond_true = ($signed(w_fwd_rs1) <  $signed(w_fwd_rs2));
            F3_BGE:  w_cond_true = ($signed(w_fwd_rs1) >= $signed(w_fwd_rs2));
            F3_BLTU: w_cond_true = (w_fwd_rs1 <  w_fwd_rs2);
            F3_BGEU: w_cond_true = (w_fwd_rs1 >= w_fwd_rs2);
            default: w_cond_true = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Redirect. JALR clears bit 0 only; bit 1 is passed through and any
    // misalignment is left for a later stage to trap.
    // ------------------------------------------------------------------
    assign w_is_jump       = idex_jump | idex_jalr;
    assign w_jalr_sum      = w_fwd_rs1 + idex_imm;
    assign w_pc_rel_target = idex_pc + idex_imm;
    assign w_link          = idex_pc + XLEN'(4);

    assign redirect_valid = idex_valid & ~mem_stall &
                            (w_is_jump | (idex_branch & w_cond_true));
    assign redirect_pc    = idex_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0}
                                      : w_pc_rel_target;

    // ------------------------------------------------------------------
    // EX/MEM next value. Control bits are qualified by idex_valid so a
    // bubble can never write; jumps register the link address so that a
    // dependent instruction forwarding rd gets pc+4.
    // ------------------------------------------------------------------
    always_comb begin
        w_exmem_next            = '0;
        w_exmem_next.valid      = idex_valid;
        w_exmem_next.alu_result = w_is_jump ? w_link : w_alu_result;
        w_exmem_next.store_data = w_fwd_rs2;
        w_exmem_next.rd         = idex_rd;
        w_exmem_next.funct3     = idex_funct3;
        w_exmem_next.regwrite   = idex_regwrite & idex_valid;
        w_exmem_next.memread    = idex_memread  & idex_valid;
        w_exmem_next.memwrite   = idex_memwrite & idex_valid;
        w_exmem_next.memtoreg   = idex_memtoreg & idex_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exmem <= '0;
        end else if (!mem_stall) begin
            r_exmem <= w_exmem_next;
        end
    end

    assign exmem_valid      = r_exmem.valid;
    assign exmem_alu_result = r_exmem.alu_result;
    assign exmem_store_data = r_exmem.store_data;
    assign exmem_rd         = r_exmem.rd;
    assign exmem_funct3     = r_exmem.funct3;
    assign exmem_regwrite   = r_exmem.regwrite;
    assign exmem_memread    = r_exmem.memread;
    assign exmem_memwrite   = r_exmem.memwrite;
    assign exmem_memtoreg   = r_exmem.memtoreg;

endmodule : ex_stage
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage. A driver issues directed
//               and random ID/EX instructions and pushes predictions from a
//               reference model; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_valid;
    logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [4:0]  idex_rd;
    logic [3:0]  idex_alu_op;
    logic        idex_alusrc_a, idex_alusrc_b, idex_branch, idex_jump, idex_jalr;
    logic [2:0]  idex_funct3;
    logic        idex_memread, idex_memwrite, idex_regwrite, idex_memtoreg;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] memwb_wdata;
    logic        mem_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exmem_valid;
    logic [31:0] exmem_alu_result, exmem_store_data;
    logic [4:0]  exmem_rd;
    logic [2:0]  exmem_funct3;
    logic        exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg;

    ex_stage #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .idex_valid       (idex_valid),
        .idex_pc          (idex_pc),
        .idex_rs1_data    (idex_rs1_data),
        .idex_rs2_data    (idex_rs2_data),
        .idex_imm         (idex_imm),
        .idex_rd          (idex_rd),
        .idex_alu_op      (idex_alu_op),
        .idex_alusrc_a    (idex_alusrc_a),
        .idex_alusrc_b    (idex_alusrc_b),
        .idex_branch      (idex_branch),
        .idex_jump        (idex_jump),
        .idex_jalr        (idex_jalr),
        .idex_funct3      (idex_funct3),
        .idex_memread     (idex_memread),
        .idex_memwrite    (idex_memwrite),
        .idex_regwrite    (idex_regwrite),
        .idex_memtoreg    (idex_memtoreg),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .memwb_wdata      (memwb_wdata),
        .mem_stall        (mem_stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .exmem_valid      (exmem_valid),
        .exmem_alu_result (exmem_alu_result),
        .exmem_store_data (exmem_store_data),
        .exmem_rd         (exmem_rd),
        .exmem_funct3     (exmem_funct3),
        .exmem_regwrite   (exmem_regwrite),
        .exmem_memread    (exmem_memread),
        .exmem_memwrite   (exmem_memwrite),
        .exmem_memtoreg   (exmem_memtoreg)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [31:0] pc, rs1, rs2, imm, memwb;
        logic [4:0]  rd;
        logic [3:0]  op;
        bit          asrc_a, asrc_b, branch, jump, jalr;
        logic [2:0]  f3;
        bit          memread, memwrite, regwrite, memtoreg, stall;
        logic [1:0]  fa, fb;
    } stim_t;

    // Model of what EX/MEM should hold; 'full' means the data fields are
    // defined (after reset or a real instruction), not don't-care.
    typedef struct {
        bit          valid;
        logic [31:0] alu, store;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          regwrite, memread, memwrite, memtoreg, full;
    } exp_t;

    typedef struct {
        bit          v;
        logic [31:0] pc;
    } rexp_t;

    exp_t  m;
    exp_t  pending;
    bit    have_pending = 1'b0;
    exp_t  exq[$];
    rexp_t rq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int          sa, sb;
        int unsigned sh;
        sa = a; sb = b; sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * (32'd1 << sh);
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a / (33'd1 << sh);
            4'd7:    return sa >>> sh;
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit taken_ref(input logic [2:0] f3, input logic [31:0] x,
                                     input logic [31:0] y);
        int sx, sy;
        sx = x; sy = y;
        case (f3)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return sx < sy;
            3'b101:  return sx >= sy;
            3'b110:  return x < y;
            3'b111:  return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] exmem_val, input logic [31:0] wb);
        if (sel == 2'b10) return exmem_val;
        if (sel == 2'b01) return wb;
        return reg_val;
    endfunction

    task automatic predict(input stim_t s);
        logic [31:0] f1, f2, a, b;
        rexp_t       r;
        f1 = fwd_ref(s.fa, s.rs1, m.alu, s.memwb);
        f2 = fwd_ref(s.fb, s.rs2, m.alu, s.memwb);
        a  = s.asrc_a ? s.pc  : f1;
        b  = s.asrc_b ? s.imm : f2;
        r.v  = s.valid && !s.stall && (s.jump || s.jalr || (s.branch && taken_ref(s.f3, f1, f2)));
        r.pc = s.jalr ? ((f1 + s.imm) & ~32'd1) : (s.pc + s.imm);
        rq.push_back(r);
        if (!s.stall) begin
            if (s.valid) begin
                m.valid    = 1'b1;
                m.alu      = (s.jump || s.jalr) ? s.pc + 32'd4 : alu_ref(a, b, s.op);
                m.store    = f2;
                m.rd       = s.rd;
                m.f3       = s.f3;
                m.regwrite = s.regwrite;
                m.memread  = s.memread;
                m.memwrite = s.memwrite;
                m.memtoreg = s.memtoreg;
                m.full     = 1'b1;
            end else begin
                m.valid    = 1'b0;
                m.regwrite = 1'b0;
                m.memread  = 1'b0;
                m.memwrite = 1'b0;
                m.memtoreg = 1'b0;
                m.full     = 1'b0;
            end
        end
        pending      = m;
        have_pending = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic apply(input stim_t s);
        idex_valid    = s.valid;     idex_pc       = s.pc;
        idex_rs1_data = s.rs1;       idex_rs2_data = s.rs2;
        idex_imm      = s.imm;       idex_rd       = s.rd;
        idex_alu_op   = s.op;        idex_alusrc_a = s.asrc_a;
        idex_alusrc_b = s.asrc_b;    idex_branch   = s.branch;
        idex_jump     = s.jump;      idex_jalr     = s.jalr;
        idex_funct3   = s.f3;        idex_memread  = s.memread;
        idex_memwrite = s.memwrite;  idex_regwrite = s.regwrite;
        idex_memtoreg = s.memtoreg;  forward_a     = s.fa;
        forward_b     = s.fb;        memwb_wdata   = s.memwb;
        mem_stall     = s.stall;
    endtask

    function automatic stim_t base(input bit valid);
        stim_t s;
        s = '{default: '0};
        s.valid = valid;
        return s;
    endfunction

    task automatic issue(input stim_t s);
        @(posedge clk);
        #1;
        if (have_pending) exq.push_back(pending);
        apply(s);
        predict(s);
    endtask

    function automatic logic [31:0] rnd32();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        int    kind;
        s = base($urandom_range(0, 7) != 0);
        s.pc     = {$urandom, 2'b00};
        s.rs1    = rnd32();   s.rs2 = rnd32();
        s.imm    = rnd32();   s.memwb = rnd32();
        s.rd     = 5'($urandom);
        s.op     = 4'($urandom_range(0, 15));
        s.asrc_a = $urandom_range(0, 1) == 1;
        s.asrc_b = $urandom_range(0, 1) == 1;
        s.f3     = 3'($urandom);
        kind     = $urandom_range(0, 5);
        s.branch = (kind == 0);
        s.jump   = (kind == 1);
        s.jalr   = (kind == 2);
        s.memread  = $urandom_range(0, 1) == 1;
        s.memwrite = $urandom_range(0, 1) == 1;
        s.regwrite = $urandom_range(0, 1) == 1;
        s.memtoreg = $urandom_range(0, 1) == 1;
        s.stall    = $urandom_range(0, 6) == 0;
        s.fa       = 2'($urandom);
        s.fb       = 2'($urandom);
        // EX/MEM forwarding is only predictable when the register holds a
        // defined value (not a bubble's don't-care data).
        if (!m.full && s.fa == 2'b10) s.fa = 2'b00;
        if (!m.full && s.fb == 2'b10) s.fb = 2'b00;
        return s;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        have_pending = 1'b0;
        rst = 1'b1;
        apply(base(1'b0));
        #1;
        chk("rst_valid",      exmem_valid,      32'd0);
        chk("rst_alu_result", exmem_alu_result, 32'd0);
        chk("rst_store_data", exmem_store_data, 32'd0);
        chk("rst_rd",         exmem_rd,         32'd0);
        chk("rst_funct3",     exmem_funct3,     32'd0);
        chk("rst_regwrite",   exmem_regwrite,   32'd0);
        chk("rst_memread",    exmem_memread,    32'd0);
        chk("rst_memwrite",   exmem_memwrite,   32'd0);
        chk("rst_memtoreg",   exmem_memtoreg,   32'd0);
        m = '{default: '0};
        m.full = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(base(1'b0));
        predict(base(1'b0));
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t  e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("redirect_valid", redirect_valid, r.v);
                if (r.v) chk("redirect_pc", redirect_pc, r.pc);
            end
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("exmem_valid",    exmem_valid,    e.valid);
                chk("exmem_regwrite", exmem_regwrite, e.regwrite);
                chk("exmem_memread",  exmem_memread,  e.memread);
                chk("exmem_memwrite", exmem_memwrite, e.memwrite);
                if (e.full) begin
                    chk("exmem_alu_result", exmem_alu_result, e.alu);
                    chk("exmem_store_data", exmem_store_data, e.store);
                    chk("exmem_rd",         exmem_rd,         e.rd);
                    chk("exmem_funct3",     exmem_funct3,     e.f3);
                    chk("exmem_memtoreg",   exmem_memtoreg,   e.memtoreg);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        stim_t s;
        rst = 1'b1;
        apply(base(1'b0));
        m = '{default: '0};
        m.full = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        predict(base(1'b0));

        for (int i = 0; i < 60; i++) issue(rnd_stim());

        // Mid-stream reset, then ADD 5 + 7.
        do_reset();
        s = base(1'b1); s.op = 4'd0; s.rs1 = 32'd5; s.rs2 = 32'd7; s.rd = 5'd3; s.regwrite = 1'b1;
        issue(s);

        // Forwarding: load 0x10 into EX/MEM, then SUB with EX/MEM - MEM/WB.
        s = base(1'b1); s.op = 4'd10; s.asrc_b = 1'b1; s.imm = 32'h10; s.regwrite = 1'b1;
        issue(s);
        s = base(1'b1); s.op = 4'd1; s.rs1 = 32'd1; s.rs2 = 32'd2; s.memwb = 32'h20;
        s.fa = 2'b10; s.fb = 2'b01; s.regwrite = 1'b1;
        issue(s);
        s.fa = 2'b11;
        issue(s);

        // BLT taken, BLTU not taken on the same operands.
        s = base(1'b1); s.branch = 1'b1; s.f3 = 3'b100; s.rs1 = 32'hFFFF_FFFF; s.rs2 = 32'd1;
        s.pc = 32'h100; s.imm = 32'd8;
        issue(s);
        s.f3 = 3'b110;
        issue(s);

        // JALR with bit 1 set in the target, then JAL with an unrelated alu_op.
        s = base(1'b1); s.jalr = 1'b1; s.rs1 = 32'h203; s.imm = 32'h0; s.pc = 32'h40;
        s.asrc_b = 1'b1; s.rd = 5'd1; s.regwrite = 1'b1;
        issue(s);
        s = base(1'b1); s.jump = 1'b1; s.pc = 32'h40; s.imm = 32'h20; s.op = 4'd5;
        s.rd = 5'd1; s.regwrite = 1'b1;
        issue(s);

        // JAL held by mem_stall for three cycles, then released.
        s = base(1'b1); s.jump = 1'b1; s.pc = 32'h80; s.imm = 32'h10; s.rd = 5'd2; s.regwrite = 1'b1;
        s.stall = 1'b1;
        repeat (3) issue(s);
        s.stall = 1'b0;
        issue(s);

        // ALU edges and a bubble carrying regwrite.
        s = base(1'b1); s.op = 4'd7; s.rs1 = 32'h8000_0000; s.asrc_b = 1'b1; s.imm = 32'h21;
        issue(s);
        s = base(1'b1); s.op = 4'd3; s.rs1 = 32'h8000_0000; s.rs2 = 32'h0;
        issue(s);
        s = base(1'b0); s.regwrite = 1'b1; s.memwrite = 1'b1; s.op = 4'd0; s.rs1 = 32'd9;
        issue(s);

        for (int i = 0; i < 400; i++) issue(rnd_stim());

        @(posedge clk);
        #1;
        if (have_pending) exq.push_back(pending);
        have_pending = 1'b0;
        apply(base(1'b0));
        repeat (3) @(posedge clk);
        if (exq.size() != 0 || rq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: pending expectations exq=%0d rq=%0d required 0", exq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ex_stage
`default_nettype wire
